// File: rtl/uart_mul_ctrl_if.sv
// Handshake bundle between the uart_mul sequencer and its RX, multiplier and TX neighbours.
// The master modport is the sequencer side; slave is the datapath side.
interface uart_mul_ctrl_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  mul_a_o;
  logic [7:0]  mul_b_o;
  logic        mul_start_o;
  logic        mul_done_i;
  logic [15:0] mul_product_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  modport master (
    input  rx_data_i,
    input  rx_valid_i,
    input  mul_done_i,
    input  mul_product_i,
    input  tx_ready_i,
    output mul_a_o,
    output mul_b_o,
    output mul_start_o,
    output tx_data_o,
    output tx_valid_o
  );

  modport slave (
    output rx_data_i,
    output rx_valid_i,
    output mul_done_i,
    output mul_product_i,
    output tx_ready_i,
    input  mul_a_o,
    input  mul_b_o,
    input  mul_start_o,
    input  tx_data_o,
    input  tx_valid_o
  );
endinterface

// File: rtl/uart_mul_ctrl.sv
// Sequencer for the uart_mul datapath: two RX operand bytes, one multiply, two TX product bytes.
// All outputs are registered; a stale first operand is dropped after an inter-byte timeout.
module uart_mul_ctrl #(
  parameter int unsigned ClockFrequency       = 12_000_000,
  parameter int unsigned DesiredBaudRate      = 9_600,
  parameter int unsigned InterByteTimeoutBits = 40,
  parameter bit          ProductMsbFirst      = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_mul_ctrl_if.master     bus,
  output logic                busy_o,
  output logic                timeout_o,
  output logic                overrun_o,
  output logic [7:0]          overrun_count_o
);

  localparam int unsigned TimeoutCycles = (ClockFrequency / DesiredBaudRate) * InterByteTimeoutBits;
  localparam int unsigned CntW          = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    MUL,
    SEND_0,
    SEND_1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic            start_q, start_d;
  logic [15:0]     prod_q, prod_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      ovc_q, ovc_d;
  logic            tx_fire;
  logic            rx_dropped;

  assign tx_fire    = tx_valid_q & bus.tx_ready_i;
  assign rx_dropped = bus.rx_valid_i &
                      ((state_q == MUL) || (state_q == SEND_0) || (state_q == SEND_1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      start_q    <= 1'b0;
      prod_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      ovc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      start_q    <= start_d;
      prod_q     <= prod_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
      ovc_q      <= ovc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    start_d    = 1'b0;
    prod_d     = prod_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    ovc_d      = ovc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid_i) begin
          a_d     = bus.rx_data_i;
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // A byte arriving in the expiry cycle is still taken as operand B.
        if (bus.rx_valid_i) begin
          b_d     = bus.rx_data_i;
          start_d = 1'b1;
          state_d = MUL;
        end else if (cnt_q == CntLast) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      MUL: begin
        if (bus.mul_done_i) begin
          prod_d     = bus.mul_product_i;
          tx_valid_d = 1'b1;
          tx_data_d  = ProductMsbFirst ? bus.mul_product_i[15:8] : bus.mul_product_i[7:0];
          state_d    = SEND_0;
        end
      end
      SEND_0: begin
        if (tx_fire) begin
          tx_data_d = ProductMsbFirst ? prod_q[7:0] : prod_q[15:8];
          state_d   = SEND_1;
        end
      end
      SEND_1: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rx_dropped) begin
      overrun_d = 1'b1;
      if (ovc_q != '1) begin
        ovc_d = ovc_q + 8'd1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.mul_a_o     = a_q;
  assign bus.mul_b_o     = b_q;
  assign bus.mul_start_o = start_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign busy_o          = busy_q;
  assign timeout_o       = timeout_q;
  assign overrun_o       = overrun_q;
  assign overrun_count_o = ovc_q;

endmodule

// File: tb/tb_uart_mul_ctrl.sv
// Directed bench for uart_mul_ctrl: default MSB-first instance plus an LSB-first,
// short-timeout instance; expected bytes are hand-computed products.
module tb_uart_mul_ctrl;

  logic       clk;
  logic       rst;
  logic       busy0, timeout0, overrun0;
  logic [7:0] count0;
  logic       busy1, timeout1, overrun1;
  logic [7:0] count1;
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned bad;

  uart_mul_ctrl_if bus0 ();
  uart_mul_ctrl_if bus1 ();

  uart_mul_ctrl dut0 (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus0.master),
    .busy_o          (busy0),
    .timeout_o       (timeout0),
    .overrun_o       (overrun0),
    .overrun_count_o (count0)
  );

  uart_mul_ctrl #(
    .InterByteTimeoutBits (2),
    .ProductMsbFirst      (1'b0)
  ) dut1 (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus1.master),
    .busy_o          (busy1),
    .timeout_o       (timeout1),
    .overrun_o       (overrun1),
    .overrun_count_o (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic rx(input bit which, input logic [7:0] b);
    if (which) begin
      bus1.rx_data_i = b; bus1.rx_valid_i = 1'b1;
      tick();
      bus1.rx_valid_i = 1'b0;
    end else begin
      bus0.rx_data_i = b; bus0.rx_valid_i = 1'b1;
      tick();
      bus0.rx_valid_i = 1'b0;
    end
  endtask

  task automatic done(input bit which, input logic [15:0] p);
    if (which) begin
      bus1.mul_done_i = 1'b1; bus1.mul_product_i = p;
      tick();
      bus1.mul_done_i = 1'b0;
    end else begin
      bus0.mul_done_i = 1'b1; bus0.mul_product_i = p;
      tick();
      bus0.mul_done_i = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus0.rx_data_i = '0; bus0.rx_valid_i = 1'b0; bus0.mul_done_i = 1'b0;
    bus0.mul_product_i = '0; bus0.tx_ready_i = 1'b1;
    bus1.rx_data_i = '0; bus1.rx_valid_i = 1'b0; bus1.mul_done_i = 1'b0;
    bus1.mul_product_i = '0; bus1.tx_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("rst_busy", busy0, 0);
    check("rst_txv", bus0.tx_valid_o, 0);
    check("rst_start", bus0.mul_start_o, 0);
    check("rst_count", count0, 0);
    check("rst_a", bus0.mul_a_o, 0);

    // 1: 03 * 05 = 000F, zero-wait multiplier
    rx(0, 8'h03);
    check("t1_a", bus0.mul_a_o, 8'h03);
    check("t1_busy", busy0, 1);
    rx(0, 8'h05);
    check("t1_start", bus0.mul_start_o, 1);
    check("t1_b", bus0.mul_b_o, 8'h05);
    done(0, 16'h000F);
    check("t1_start_off", bus0.mul_start_o, 0);
    check("t1_txv0", bus0.tx_valid_o, 1);
    check("t1_byte0", bus0.tx_data_o, 8'h00);
    tick();
    check("t1_txv1", bus0.tx_valid_o, 1);
    check("t1_byte1", bus0.tx_data_o, 8'h0F);
    tick();
    check("t1_txv_end", bus0.tx_valid_o, 0);
    check("t1_busy_end", busy0, 0);

    // 2: FF * FF = FE01 with TX stalled
    bus0.tx_ready_i = 1'b0;
    rx(0, 8'hFF); rx(0, 8'hFF);
    tick();
    check("t2_start_once", bus0.mul_start_o, 0);
    check("t2_txv_mul", bus0.tx_valid_o, 0);
    done(0, 16'hFE01);
    check("t2_byte0", bus0.tx_data_o, 8'hFE);
    bad = 0;
    repeat (10) begin
      tick();
      if (!(bus0.tx_valid_o === 1'b1 && bus0.tx_data_o === 8'hFE)) bad++;
    end
    check("t2_hold", bad[15:0], 0);
    bus0.tx_ready_i = 1'b1;
    tick();
    check("t2_byte1", bus0.tx_data_o, 8'h01);
    check("t2_txv1", bus0.tx_valid_o, 1);
    tick();
    check("t2_txv_end", bus0.tx_valid_o, 0);
    done(0, 16'h1234);
    check("t2_done_idle_busy", busy0, 0);
    check("t2_done_idle_txv", bus0.tx_valid_o, 0);

    // 3: lone operand times out after 50_000 cycles
    rx(0, 8'h12);
    repeat (49999) tick();
    check("t3_pre_timeout", timeout0, 0);
    check("t3_pre_busy", busy0, 1);
    tick();
    check("t3_timeout", timeout0, 1);
    check("t3_idle", busy0, 0);
    tick();
    check("t3_timeout_pulse", timeout0, 0);
    rx(0, 8'h02); rx(0, 8'h03);
    check("t3_a", bus0.mul_a_o, 8'h02);
    check("t3_b", bus0.mul_b_o, 8'h03);
    done(0, 16'h0006);
    check("t3_byte0", bus0.tx_data_o, 8'h00);
    tick();
    check("t3_byte1", bus0.tx_data_o, 8'h06);
    tick();
    check("t3_txv_end", bus0.tx_valid_o, 0);

    // 4: overrun in SEND_0, then saturation
    bus0.tx_ready_i = 1'b0;
    rx(0, 8'h03); rx(0, 8'h05);
    done(0, 16'h000F);
    rx(0, 8'hAA);
    check("t4_overrun", overrun0, 1);
    check("t4_count1", count0, 8'h01);
    check("t4_byte0_kept", bus0.tx_data_o, 8'h00);
    check("t4_a_kept", bus0.mul_a_o, 8'h03);
    check("t4_b_kept", bus0.mul_b_o, 8'h05);
    tick();
    check("t4_overrun_pulse", overrun0, 0);
    bus0.tx_ready_i = 1'b1;
    tick();
    check("t4_byte1", bus0.tx_data_o, 8'h0F);
    tick();
    check("t4_txv_end", bus0.tx_valid_o, 0);
    rx(0, 8'h01); rx(0, 8'h01);
    bus0.rx_data_i = 8'hAA; bus0.rx_valid_i = 1'b1;
    repeat (254) tick();
    check("t4_count_ff", count0, 8'hFF);
    repeat (2) tick();
    bus0.rx_valid_i = 1'b0;
    check("t4_count_sat", count0, 8'hFF);
    check("t4_a_after_ovr", bus0.mul_a_o, 8'h01);
    done(0, 16'h0001);
    check("t4_sat_byte0", bus0.tx_data_o, 8'h00);
    tick();
    check("t4_sat_byte1", bus0.tx_data_o, 8'h01);
    tick();

    // 5: reset while in MUL, late done ignored
    rx(0, 8'h06); rx(0, 8'h07);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_a", bus0.mul_a_o, 0);
    check("t5_b", bus0.mul_b_o, 0);
    check("t5_start", bus0.mul_start_o, 0);
    check("t5_busy", busy0, 0);
    check("t5_count", count0, 0);
    done(0, 16'h002A);
    check("t5_late_done_busy", busy0, 0);
    check("t5_late_done_txv", bus0.tx_valid_o, 0);
    rx(0, 8'h04); rx(0, 8'h04);
    done(0, 16'h0010);
    check("t5_byte0", bus0.tx_data_o, 8'h00);
    tick();
    check("t5_byte1", bus0.tx_data_o, 8'h10);
    tick();

    // 6: LSB-first instance, 10 * 11 = 0110
    rx(1, 8'h10); rx(1, 8'h11);
    check("t6_start", bus1.mul_start_o, 1);
    done(1, 16'h0110);
    check("t6_byte0", bus1.tx_data_o, 8'h10);
    tick();
    check("t6_byte1", bus1.tx_data_o, 8'h01);
    tick();
    check("t6_txv_end", bus1.tx_valid_o, 0);

    // operand B landing in the expiry cycle (2500-cycle timeout) wins
    rx(1, 8'h07);
    repeat (2499) tick();
    check("t6_race_pre_busy", busy1, 1);
    check("t6_race_pre_to", timeout1, 0);
    rx(1, 8'h08);
    check("t6_race_start", bus1.mul_start_o, 1);
    check("t6_race_no_to", timeout1, 0);
    check("t6_race_b", bus1.mul_b_o, 8'h08);
    done(1, 16'h0038);
    check("t6_race_byte0", bus1.tx_data_o, 8'h38);
    tick();
    check("t6_race_byte1", bus1.tx_data_o, 8'h00);
    tick();
    check("t6_race_idle", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
